// File: rtl/cam_dvp_pkg.sv
// Shared types for the DVP camera transmitter:
// pattern select, frame FSM states, bar colours.
package cam_dvp_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_EXT   = 2'd3
  } pattern_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    unique case (idx)
      3'd0: c = 16'hFFFF;
      3'd1: c = 16'hFFE0;
      3'd2: c = 16'h07FF;
      3'd3: c = 16'h07E0;
      3'd4: c = 16'hF81F;
      3'd5: c = 16'hF800;
      3'd6: c = 16'h001F;
      3'd7: c = 16'h0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Combinational RGB565 pixel source: colour bars,
// horizontal ramp, 32x32 checker or external pixel.
module dvp_pattern_gen
  import cam_dvp_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic [12:0] x,
  input  logic        y_tile,
  input  pattern_t    pattern,
  input  logic [15:0] px_data,
  output logic [15:0] pix
);

  localparam int BAR_W = H_ACTIVE / 8;

  always_comb begin
    pix = 16'h0000;
    unique case (pattern)
      PAT_BARS:  pix = bar_colour(3'(x / 13'(BAR_W)));
      PAT_RAMP:  pix = 16'(x);
      PAT_CHECK: pix = (x[5] ^ y_tile) ? 16'hFFFF : 16'h0000;
      PAT_EXT:   pix = px_data;
    endcase
  end

endmodule

// File: rtl/cam_dvp_tx.sv
// OV7670-style DVP transmitter: VSYNC/HREF timing and
// one RGB565 byte per clk, high byte first.
module cam_dvp_tx
  import cam_dvp_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 288,
  parameter int VS_LINES = 3,
  parameter int V_BACK   = 17,
  parameter int V_FRONT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern,
  input  logic [15:0] px_data,
  output logic        px_rd,
  output logic [12:0] px_addr,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int L    = 2 * H_ACTIVE + H_BLANK;
  localparam int HW   = (L > 1) ? $clog2(L) : 1;
  localparam int VMAX = max_int(max_int(VS_LINES, V_BACK),
                                max_int(V_ACTIVE, V_FRONT));
  localparam int VW   = (VMAX > 1) ? $clog2(VMAX) : 1;

  localparam logic [HW-1:0] H_LAST  = HW'(L - 1);
  localparam logic [HW:0]   H_BYTES = (HW + 1)'(2 * H_ACTIVE);

  state_t        state, nxt_state;
  logic [HW-1:0] h, nxt_h;
  logic [VW-1:0] v, nxt_v;
  pattern_t      pat_q, pat_n;
  logic          frame_start;
  logic [15:0]   ext_pix, pix;
  logic          nxt_href, nxt_done, nxt_rd, pre_rd;
  logic          y_tile;

  function automatic logic [VW-1:0] last_line(input state_t s);
    logic [VW-1:0] r;
    unique case (s)
      ST_VSYNC:  r = VW'(VS_LINES - 1);
      ST_VBACK:  r = VW'(V_BACK - 1);
      ST_ACTIVE: r = VW'(V_ACTIVE - 1);
      ST_VFRONT: r = VW'(V_FRONT - 1);
      default:   r = '0;
    endcase
    return r;
  endfunction

  function automatic state_t first_stage();
    if (VS_LINES > 0) return ST_VSYNC;
    if (V_BACK > 0) return ST_VBACK;
    return ST_ACTIVE;
  endfunction

  always_comb begin
    nxt_state   = state;
    nxt_h       = h;
    nxt_v       = v;
    frame_start = 1'b0;
    if (state == ST_IDLE) begin
      if (enable) begin
        nxt_state   = first_stage();
        nxt_h       = '0;
        nxt_v       = '0;
        frame_start = 1'b1;
      end
    end else if (h != H_LAST) begin
      nxt_h = h + 1'b1;
    end else begin
      nxt_h = '0;
      nxt_v = v + 1'b1;
      if (v == last_line(state)) begin
        nxt_v = '0;
        unique case (1'b1)
          state == ST_VSYNC:
            nxt_state = (V_BACK > 0) ? ST_VBACK : ST_ACTIVE;
          state == ST_VBACK:
            nxt_state = ST_ACTIVE;
          state == ST_ACTIVE && V_FRONT > 0:
            nxt_state = ST_VFRONT;
          default: begin
            nxt_state   = enable ? first_stage() : ST_IDLE;
            frame_start = enable;
          end
        endcase
      end
    end
  end

  assign pat_n  = frame_start ? pattern_t'(pattern) : pat_q;
  assign y_tile = |(16'(nxt_v) & 16'h0020);

  // Outputs are registered from the next-cycle position,
  // so each output describes the cycle that follows.
  always_comb begin
    nxt_href = (nxt_state == ST_ACTIVE) && ({1'b0, nxt_h} < H_BYTES);
    nxt_done = (nxt_h == H_LAST) && (
      (nxt_state == ST_VFRONT && nxt_v == last_line(ST_VFRONT)) ||
      (nxt_state == ST_ACTIVE && V_FRONT == 0 &&
       nxt_v == last_line(ST_ACTIVE)));
    pre_rd = (nxt_h == H_LAST) && (
      (nxt_state == ST_ACTIVE && nxt_v != last_line(ST_ACTIVE)) ||
      (nxt_state == ST_VBACK && nxt_v == last_line(ST_VBACK)) ||
      (nxt_state == ST_VSYNC && V_BACK == 0 &&
       nxt_v == last_line(ST_VSYNC)));
    nxt_rd = 1'b0;
    if (pat_n == PAT_EXT) begin
      nxt_rd = pre_rd ||
        (nxt_state == ST_ACTIVE && nxt_h[0] &&
         ({1'b0, nxt_h} + 1'b1 < H_BYTES));
    end
  end

  dvp_pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_gen (
    .x       (13'(nxt_h >> 1)),
    .y_tile  (y_tile),
    .pattern (pat_n),
    .px_data (px_rd ? px_data : ext_pix),
    .pix     (pix)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      h          <= '0;
      v          <= '0;
      pat_q      <= PAT_BARS;
      ext_pix    <= 16'h0000;
      px_rd      <= 1'b0;
      px_addr    <= 13'd0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      data       <= 8'h00;
      frame_done <= 1'b0;
      frame_cnt  <= 16'h0000;
      busy       <= 1'b0;
    end else begin
      state <= nxt_state;
      h     <= nxt_h;
      v     <= nxt_v;
      pat_q <= pat_n;
      if (px_rd) ext_pix <= px_data;
      px_rd <= nxt_rd;
      if (!nxt_rd)
        px_addr <= 13'd0;
      else if (nxt_h == H_LAST)
        px_addr <= 13'd0;
      else
        px_addr <= 13'((nxt_h + 1'b1) >> 1);
      vsync <= (nxt_state == ST_VSYNC);
      href  <= nxt_href;
      if (!nxt_href)
        data <= 8'h00;
      else
        data <= nxt_h[0] ? pix[7:0] : pix[15:8];
      frame_done <= nxt_done;
      if (nxt_done) frame_cnt <= frame_cnt + 1'b1;
      busy <= (nxt_state != ST_IDLE);
    end
  end

endmodule
